// File: rtl/pe_result_drain_if.sv
// pe_result_drain_if
// Bundles the result-drain handshake between the PE array, the drain block
// and the downstream sink.
//   y_in        per-lane 2*DW-bit signed dot products (lane i at [i])
//   done_in     per-lane done flags
//   blk_ready   drain block can accept a new block
//   out_valid   out_data/out_idx/out_last are valid
//   out_ready   sink accepts the current element
//   out_data    requantized DW-bit signed result
//   out_idx     global output-row index
//   out_last    final element of an M-row vector
//   err_overrun sticky: capture arrived while draining
// The slave modport is the drain block; the master modport is the
// environment (PE array plus sink).
interface pe_result_drain_if #(
    parameter int PE_NUM = 8,
    parameter int DW     = 16,
    parameter int IDX_W  = 6
);
    logic [PE_NUM-1:0][2*DW-1:0] y_in;
    logic [PE_NUM-1:0]           done_in;
    logic                        blk_ready;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [DW-1:0]        out_data;
    logic [IDX_W-1:0]            out_idx;
    logic                        out_last;
    logic                        err_overrun;

    modport slave (
        input  y_in, done_in, out_ready,
        output blk_ready, out_valid, out_data, out_idx, out_last, err_overrun
    );

    modport master (
        output y_in, done_in, out_ready,
        input  blk_ready, out_valid, out_data, out_idx, out_last, err_overrun
    );
endinterface

// File: rtl/pe_result_drain.sv
// pe_result_drain
// Waits for every PE lane to report done, captures all lanes in one cycle
// (requantized to DW bits with round-half-up and saturation), then streams
// them out one per cycle over valid/ready, tagged with the global row index.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pe_result_drain_if slave modport (see interface header)
module pe_result_drain #(
    parameter int PE_NUM    = 8,
    parameter int DW        = 16,
    parameter int M         = 64,
    parameter int OUT_SHIFT = 8,
    parameter int IDX_W     = $clog2(M)
) (
    input  logic               clk,
    input  logic               rst,
    pe_result_drain_if.slave   bus
);

    localparam int BLK_NUM = M / PE_NUM;
    localparam int LW      = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int BW      = (BLK_NUM > 1) ? $clog2(BLK_NUM) : 1;

    localparam logic [LW-1:0] LANE_LAST = LW'(PE_NUM - 1);
    localparam logic [BW-1:0] BLK_LAST  = BW'(BLK_NUM - 1);

    // Rounding constant and saturation bounds, all in the 2*DW+1 bit domain
    // so the rounding add can never wrap.
    localparam logic signed [2*DW:0] RND  = {{(2*DW){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    localparam logic signed [2*DW:0] MAXV = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW:0] MINV = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                state;
    logic [LW-1:0]         lane;
    logic [BW-1:0]         blk_cnt;
    logic                  all_done_q;
    logic                  err_q;
    logic signed [DW-1:0]  data_buf [PE_NUM];

    logic all_done;
    logic capture;

    // Round half toward +inf: add half an LSB of the result, then an
    // arithmetic shift floors the value. Out-of-range results clamp.
    function automatic logic signed [DW-1:0] requant(input logic signed [2*DW-1:0] y);
        logic signed [2*DW:0] t;
        t = $signed({y[2*DW-1], y}) + RND;
        t = t >>> OUT_SHIFT;
        if (t > MAXV)
            return MAXV[DW-1:0];
        else if (t < MINV)
            return MINV[DW-1:0];
        else
            return t[DW-1:0];
    endfunction

    // A capture fires only on the rising edge of the combined done flag, so
    // both pulse-style and level-style done signalling start exactly one block.
    always_comb begin
        all_done = &bus.done_in;
        capture  = all_done & ~all_done_q;
    end

    // Main FSM: IDLE waits for a capture and loads the requantized buffer;
    // DRAIN walks the lanes on each handshake and advances the block counter
    // once the final lane is taken. A capture seen while draining leaves the
    // buffer untouched and latches the overrun flag until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lane       <= '0;
            blk_cnt    <= '0;
            all_done_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < PE_NUM; i++)
                data_buf[i] <= '0;
        end else begin
            all_done_q <= all_done;
            case (state)
                IDLE: begin
                    if (capture) begin
                        for (int i = 0; i < PE_NUM; i++)
                            data_buf[i] <= requant($signed(bus.y_in[i]));
                        lane  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (capture)
                        err_q <= 1'b1;
                    if (bus.out_ready) begin
                        if (lane == LANE_LAST) begin
                            lane    <= '0;
                            state   <= IDLE;
                            blk_cnt <= (blk_cnt == BLK_LAST) ? '0 : blk_cnt + 1'b1;
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is decoded from registered state only, so nothing on
    // y_in or done_in reaches the outputs combinationally.
    always_comb begin
        bus.blk_ready   = (state == IDLE);
        bus.out_valid   = (state == DRAIN);
        bus.out_data    = data_buf[lane];
        bus.out_idx     = IDX_W'(blk_cnt) * IDX_W'(PE_NUM) + IDX_W'(lane);
        bus.out_last    = (state == DRAIN) && (lane == LANE_LAST) && (blk_cnt == BLK_LAST);
        bus.err_overrun = err_q;
    end

endmodule

// File: tb/tb_pe_result_drain.sv
// tb_pe_result_drain
// Directed, table-driven bench for pe_result_drain (PE_NUM=8, DW=16, M=64,
// OUT_SHIFT=8). Inputs are driven and outputs sampled on the falling edge.
module tb_pe_result_drain;

    localparam int PE_NUM    = 8;
    localparam int DW        = 16;
    localparam int M         = 64;
    localparam int OUT_SHIFT = 8;
    localparam int IDX_W     = 6;

    typedef struct {
        logic signed [2*DW-1:0] y;
        logic signed [DW-1:0]   exp;
    } vec_t;

    logic clk;
    logic rst;

    pe_result_drain_if #(.PE_NUM(PE_NUM), .DW(DW), .IDX_W(IDX_W)) bus ();

    pe_result_drain #(
        .PE_NUM(PE_NUM), .DW(DW), .M(M), .OUT_SHIFT(OUT_SHIFT), .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int expBlk     = 0;
    int cyc;

    vec_t                   vecs [16];
    logic signed [2*DW-1:0] curY   [PE_NUM];
    logic signed [DW-1:0]   curExp [PE_NUM];

    // Counts one comparison and reports it if it disagrees.
    task automatic checkOutput(input string name, input longint act, input longint exp);
        checkCount++;
        if (act == exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Presents the current block on y_in and raises every done flag.
    task automatic applyStimulus();
        for (int i = 0; i < PE_NUM; i++)
            bus.y_in[i] = curY[i];
        bus.done_in = '1;
    endtask

    task automatic loadFromTable(input int base);
        for (int i = 0; i < PE_NUM; i++) begin
            curY[i]   = vecs[base + i].y;
            curExp[i] = vecs[base + i].exp;
        end
    endtask

    // Value v placed as v*256+100 rounds back down to v.
    task automatic loadPattern(input int b);
        for (int i = 0; i < PE_NUM; i++) begin
            curY[i]   = 32'((b * PE_NUM + i) * 256 + 100);
            curExp[i] = 16'(b * PE_NUM + i);
        end
    endtask

    // Drains up to n elements. bpMode=1 drives out_ready as 1,0,0,1,0,0,...
    // Each negedge checks the presented element; a handshake at the next
    // posedge advances the expected element. After a full block, checks the
    // return to IDLE and advances the expected block counter.
    task automatic drainBlock(input int n, input bit bpMode, output int cycles);
        int k;
        k = 0;
        cycles = 0;
        while (k < n && cycles < 64) begin
            @(negedge clk);
            bus.done_in   = '0;
            bus.out_ready = bpMode ? ((cycles % 3) == 0) : 1'b1;
            cycles++;
            checkOutput($sformatf("valid b%0d e%0d", expBlk, k), bus.out_valid, 1);
            checkOutput($sformatf("blk_ready b%0d e%0d", expBlk, k), bus.blk_ready, 0);
            checkOutput($sformatf("data b%0d e%0d", expBlk, k), bus.out_data, curExp[k]);
            checkOutput($sformatf("idx b%0d e%0d", expBlk, k), bus.out_idx, expBlk * PE_NUM + k);
            checkOutput($sformatf("last b%0d e%0d", expBlk, k), bus.out_last,
                        (expBlk == M / PE_NUM - 1 && k == PE_NUM - 1) ? 1 : 0);
            if (bus.out_ready)
                k++;
        end
        checkOutput("drain_budget", k, n);
        if (n == PE_NUM) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            checkOutput("idle blk_ready", bus.blk_ready, 1);
            checkOutput("idle valid", bus.out_valid, 0);
            expBlk = (expBlk + 1) % (M / PE_NUM);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " blk_ready"}, bus.blk_ready, 1);
        checkOutput({tag, " valid"}, bus.out_valid, 0);
        checkOutput({tag, " data"}, bus.out_data, 0);
        checkOutput({tag, " idx"}, bus.out_idx, 0);
        checkOutput({tag, " last"}, bus.out_last, 0);
        checkOutput({tag, " err"}, bus.err_overrun, 0);
    endtask

    initial begin
        // Basic capture: lane i = i*256 -> i
        for (int i = 0; i < PE_NUM; i++) begin
            vecs[i].y   = 32'(i * 256);
            vecs[i].exp = 16'(i);
        end
        // Rounding and saturation corners
        vecs[8]  = '{32'h0001_2380, 16'sd292};
        vecs[9]  = '{-32'sd384, -16'sd1};
        vecs[10] = '{32'h7FFF_FFFF, 16'sd32767};
        vecs[11] = '{-32'sh0100_0000, -16'sd32768};
        vecs[12] = '{32'sd127, 16'sd0};
        vecs[13] = '{32'sd128, 16'sd1};
        vecs[14] = '{-32'sd128, 16'sd0};
        vecs[15] = '{32'h007F_FF7F, 16'sd32767};

        rst           = 1'b1;
        bus.y_in      = '0;
        bus.done_in   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        // Table-driven blocks: basic ramp, then the rounding corners
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            loadFromTable(t * PE_NUM);
            applyStimulus();
            drainBlock(PE_NUM, 1'b0, cyc);
            checkOutput($sformatf("drain_cycles tbl%0d", t), cyc, PE_NUM);
        end

        // Backpressure on the ramp block
        @(negedge clk);
        loadFromTable(0);
        applyStimulus();
        drainBlock(PE_NUM, 1'b1, cyc);

        // Finish the vector (blocks 3..7), then the wrap back to idx 0
        for (int b = 3; b < M / PE_NUM + 1; b++) begin
            @(negedge clk);
            loadPattern(b % (M / PE_NUM));
            applyStimulus();
            drainBlock(PE_NUM, 1'b0, cyc);
        end

        // Overrun: second done edge while stalled in DRAIN
        @(negedge clk);
        loadFromTable(0);
        applyStimulus();
        @(negedge clk);
        bus.done_in   = '0;
        bus.out_ready = 1'b0;
        checkOutput("ovr pre err", bus.err_overrun, 0);
        @(negedge clk);
        for (int i = 0; i < PE_NUM; i++)
            bus.y_in[i] = 32'h7FFF_FFFF;
        bus.done_in = '1;
        @(negedge clk);
        bus.done_in = '0;
        checkOutput("ovr err set", bus.err_overrun, 1);
        checkOutput("ovr data held", bus.out_data, curExp[0]);
        drainBlock(PE_NUM, 1'b0, cyc);
        repeat (3) @(negedge clk);
        checkOutput("ovr err sticky", bus.err_overrun, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetValues("ovr reset");
        expBlk = 0;

        // Reset mid-drain: after lane 3 of block 2 is accepted
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            loadPattern(b);
            applyStimulus();
            drainBlock(PE_NUM, 1'b0, cyc);
        end
        @(negedge clk);
        loadPattern(2);
        applyStimulus();
        drainBlock(4, 1'b0, cyc);
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkResetValues("mid reset");
        expBlk = 0;
        loadPattern(5);
        applyStimulus();
        drainBlock(PE_NUM, 1'b0, cyc);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Downstream stage of the PE array in the matrix-vector datapath. It waits until every PE reports done, then captures the PE_NUM wide-precision dot products in one cycle. Each result is requantized to DW bits with round-half-up and saturation, and the block streams the values out one element per cycle over a valid/ready handshake, tagged with the global output-row index. It counts row blocks so that out_last marks the final element of a full M-row result vector, and it reports when the PE array may be started on the next block.

## Interface
- PE_NUM, 8: number of PE lanes captured per block.
- DW, 16: output width; input results are 2*DW.
- M, 64: rows per output vector; must be a nonzero multiple of PE_NUM.
- OUT_SHIFT, 8: requantization right-shift amount, 1..2*DW-1.
- IDX_W, $clog2(M): width of out_idx.
- clk  in  1  clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- y_in  in  PE_NUM x 2*DW signed  per-lane dot-product results.
- done_in  in  PE_NUM  per-lane done flags.
- blk_ready  out  1  high when a new block can be captured; the controller starts the PE array only while this is high.
- out_valid  out  1  out_data, out_idx and out_last are valid.
- out_ready  in  1  sink accepts the current element.
- out_data  out  DW signed  requantized result.
- out_idx  out  IDX_W  global row index = blk_cnt*PE_NUM + lane.
- out_last  out  1  high with element M-1 of the vector.
- err_overrun  out  1  sticky flag: a capture event arrived while the block was draining.

## Operation
- all_done = AND of done_in.
- Capture event = all_done high this cycle and low the previous cycle (rising edge of all_done). This accepts both pulse-style and level-style done flags.
- The block has two states:
  - IDLE: blk_ready=1, out_valid=0. On a capture event, load all PE_NUM requantized lanes into the buffer, set lane=0, and go to DRAIN.
  - DRAIN: blk_ready=0, out_valid=1, out_data=buf[lane].
    - On a handshake (out_valid & out_ready), lane increments.
    - On the handshake of lane PE_NUM-1, return to IDLE and advance blk_cnt. blk_cnt wraps to 0 after block M/PE_NUM-1.
- A capture event during DRAIN is ignored (the buffer is not modified) and sets err_overrun. Only reset clears err_overrun.
- Requantization is applied per lane at capture, computed in 2*DW+1 bits:
  - t = y + 2^(OUT_SHIFT-1), then arithmetic shift right by OUT_SHIFT (rounds half toward +inf).
  - Saturate t to the range [-2^(DW-1), 2^(DW-1)-1].
- out_last = DRAIN && lane==PE_NUM-1 && blk_cnt==M/PE_NUM-1.
- While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- Reset at any time, including mid-DRAIN, discards the buffered block and restarts the vector at blk_cnt=0.

## Timing
- Reset values: blk_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, err_overrun=0; internal blk_cnt=0, lane=0, state=IDLE.
- Latency: capture event sampled at edge t → out_valid=1 with lane 0 from cycle t+1.
- Throughput: with out_ready held high, one element per cycle, so a block drains in PE_NUM cycles.
- After the lane PE_NUM-1 handshake at edge u: from cycle u+1, blk_ready=1 and out_valid=0.
- The earliest next capture is sampled at edge u+1. Per-block overhead is therefore 1 cycle beyond PE_NUM.
- All outputs are registered or decoded from registered state only; there is no combinational path from y_in or done_in to any output.
- out_ready is used only during DRAIN and is ignored in IDLE.

## Test plan
- Basic capture (PE_NUM=8, OUT_SHIFT=8):
  - Stimulus: lane i = i*256, all done_in pulsed for 1 cycle, out_ready=1.
  - Response: out_data 0..7 on 8 consecutive cycles starting 1 cycle after the pulse, out_idx 0..7, blk_ready low exactly for those 8 cycles.
- Rounding and saturation, one lane each:
  - 0x00012380 → 292.
  - -384 → -1.
  - 0x7FFFFFFF → 32767.
  - -0x01000000 → -32768.
  - 127 → 0.
  - 128 → 1.
- Backpressure:
  - Stimulus: toggle out_ready in the pattern 1,0,0,1,...
  - Response: each element holds stable until its handshake; no element is lost or duplicated; all 8 appear in order.
- Vector wrap (M=64):
  - Stimulus: 8 blocks of data.
  - Response: out_idx runs 0..63; out_last is high only on idx 63; the 9th block restarts at idx 0.
- Overrun:
  - Stimulus: a second done_in rising edge during DRAIN with out_ready=0.
  - Response: err_overrun=1 and stays 1; the buffered data is unchanged; only rst clears the flag.
- Reset mid-drain:
  - Stimulus: assert rst after lane 3 of block 2 has been accepted.
  - Response: outputs return to reset values next cycle; the next capture emits idx 0..7.
